// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default geometry and Gray/binary pointer conversion,
// used by both the read and write controllers.
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH  = 64;
  localparam int unsigned FIFO_ADDR_W = 6;
  localparam int unsigned GRAY_W      = 32;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
    logic [GRAY_W-1:0] bin;
    bin = gray;
    for (int i = 1; i < int'(GRAY_W); i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Two-flop synchronizer for a multi-bit Gray-coded pointer crossing into the
// local clock domain.
module ptr_sync #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller with first-word-fall-through output.
// Define FIFO_RD_LEVEL_EN to add the r_level port and a level-based r_aempty.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = FIFO_DEPTH,
  parameter int unsigned ADDR_W    = FIFO_ADDR_W,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic              r_clk,
  input  logic              r_rst_n,
  input  logic [ADDR_W:0]   w_gptr,
  output logic [ADDR_W:0]   r_gptr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              r_valid,
  input  logic [WIDTH-1:0]  r_data,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              r_empty,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDR_W:0]   r_level,
`endif
  output logic              r_aempty
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  if ((DEPTH != (32'd1 << ADDR_W)) || (AE_THRESH > DEPTH)) begin : g_bad_cfg
    $error("fifo_rd_ctrl: DEPTH must equal 2**ADDR_W and AE_THRESH must not exceed DEPTH");
  end

  logic [PTR_W-1:0] w_wq2;
  logic [PTR_W-1:0] r_rbin;
  logic [PTR_W-1:0] w_rbin_nxt;
  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;

  ptr_sync #(
    .WIDTH (PTR_W)
  ) u_wptr_sync (
    .i_clk   (r_clk),
    .i_rst_n (r_rst_n),
    .i_d     (w_gptr),
    .o_q     (w_wq2)
  );

  assign r_empty    = (r_gptr == w_wq2);
  assign w_rbin_nxt = r_rbin + PTR_W'(1);
  assign r_addr     = r_rbin[ADDR_W-1:0];
  assign out_data   = r_data;
  assign out_valid  = (r_state == ST_VALID);

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A read is issued only when the output slot is free or being vacated this cycle.
  always_comb begin
    w_state_nxt = r_state;
    r_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        r_valid = !r_empty;
        if (!r_empty) begin
          w_state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        r_valid = !r_empty && out_ready;
        if (out_ready && r_empty) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_rbin <= '0;
      r_gptr <= '0;
    end else if (r_valid) begin
      r_rbin <= w_rbin_nxt;
      r_gptr <= PTR_W'(bin2gray(GRAY_W'(w_rbin_nxt)));
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  // Modular subtraction keeps the level correct across pointer wrap.
  assign r_level  = PTR_W'(gray2bin(GRAY_W'(w_wq2))) - r_rbin;
  assign r_aempty = (r_level <= PTR_W'(AE_THRESH));
`else
  assign r_aempty = r_empty;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: randomized writes/backpressure against a
// counter-and-queue reference model of the read side.
module tb_fifo_rd_ctrl;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned AE     = 4;

  logic              r_clk = 1'b0;
  logic              r_rst_n;
  logic [ADDR_W:0]   w_gptr;
  logic [ADDR_W:0]   r_gptr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              r_empty;
  logic              r_aempty;
`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_W:0]   r_level;
`endif

  always #5 r_clk = ~r_clk;

  fifo_rd_ctrl #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .WIDTH     (WIDTH),
    .AE_THRESH (AE)
  ) dut (
    .r_clk     (r_clk),
    .r_rst_n   (r_rst_n),
    .w_gptr    (w_gptr),
    .r_gptr    (r_gptr),
    .r_addr    (r_addr),
    .r_valid   (r_valid),
    .r_data    (r_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_empty   (r_empty),
`ifdef FIFO_RD_LEVEL_EN
    .r_level   (r_level),
`endif
    .r_aempty  (r_aempty)
  );

  // Memory behind the controller: one-cycle registered read, holds when idle.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge r_clk) begin
    if (r_valid) r_data <= mem[r_addr];
  end

  // Reference model state: counts of words written, visible to reader, read.
  int               wcnt;
  int               s1;
  int               vis;
  int               rd_cnt;
  bit               holding;
  bit               m_emp;
  bit               m_rv;
  logic [WIDTH-1:0] q [$];
  int               errors = 0;
  int               checks = 0;
  int               ov_cnt;
  int               pushed;

  function automatic logic [ADDR_W:0] gray_of(input int n);
    logic [ADDR_W:0] b;
    b = (ADDR_W+1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Writer sees two r_clk edges of latency before the reader can use a word.
  always @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      s1      = 0;
      vis     = 0;
      rd_cnt  = 0;
      holding = 0;
    end else begin
      m_emp = (vis == rd_cnt);
      m_rv  = !m_emp && (!holding || out_ready);
      if (holding && out_ready) void'(q.pop_front());
      if (m_rv) begin
        rd_cnt++;
        holding = 1;
      end else if (holding && out_ready) begin
        holding = 0;
      end
      vis = s1;
      s1  = wcnt;
    end
  end

  task automatic run_checks();
    bit exp_empty;
    bit exp_rv;
    int lvl;
    exp_empty = (vis == rd_cnt);
    exp_rv    = r_rst_n && !exp_empty && (!holding || out_ready);
    lvl       = vis - rd_cnt;
    check_eq("r_valid", 32'(r_valid), 32'(exp_rv));
    check_eq("out_valid", 32'(out_valid), 32'(holding));
    check_eq("r_empty", 32'(r_empty), 32'(exp_empty));
    check_eq("r_gptr", 32'(r_gptr), 32'(gray_of(rd_cnt)));
    check_eq("r_addr", 32'(r_addr), 32'(rd_cnt % DEPTH));
    if (holding) begin
      if (q.size() == 0) check_eq("model_q_empty", 32'd1, 32'd0);
      else check_eq("out_data", out_data, q[0]);
    end
`ifdef FIFO_RD_LEVEL_EN
    check_eq("r_level", 32'(r_level), 32'(lvl));
    check_eq("r_aempty", 32'(r_aempty), 32'(lvl <= int'(AE)));
`else
    check_eq("r_aempty", 32'(r_aempty), 32'(exp_empty));
    if (lvl < 0) check_eq("model_level", 32'(lvl), 32'd0);
`endif
  endtask

  task automatic tick();
    @(negedge r_clk);
    run_checks();
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    mem[wcnt % DEPTH] = d;
    q.push_back(d);
    wcnt++;
    w_gptr = gray_of(wcnt);
  endtask

  initial begin
    r_rst_n   = 1'b0;
    out_ready = 1'b0;
    wcnt      = 0;
    w_gptr    = '0;
    #1;
    check_eq("rst_r_empty", 32'(r_empty), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_r_valid", 32'(r_valid), 32'd0);
    check_eq("rst_r_aempty", 32'(r_aempty), 32'd1);
    check_eq("rst_r_addr", 32'(r_addr), 32'd0);
    check_eq("rst_r_gptr", 32'(r_gptr), 32'd0);
    repeat (3) tick();
    r_rst_n = 1'b1;

    // Idle with nothing written: never a read.
    repeat (20) tick();

    // Single word: read on the second edge, visible after the third.
    push(32'hA5A5_A5A5);
    tick();
    tick();
    check_eq("one_r_valid", 32'(r_valid), 32'd1);
    tick();
    check_eq("one_out_valid", 32'(out_valid), 32'd1);
    check_eq("one_out_data", out_data, 32'hA5A5_A5A5);
    check_eq("one_r_gptr", 32'(r_gptr), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (3) tick();

    // Eight preloaded words drained back-to-back.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h1000 + 32'(i));
    ov_cnt = 0;
    repeat (15) begin
      tick();
      if (out_valid) ov_cnt++;
    end
    check_eq("burst8_valid_cycles", 32'(ov_cnt), 32'd8);
    check_eq("burst8_empty", 32'(r_empty), 32'd1);
    check_eq("burst8_idle", 32'(out_valid), 32'd0);

    // Backpressure: head word must stay put, no reads.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h2000 + 32'(i));
    repeat (4) tick();
    repeat (10) begin
      tick();
      check_eq("stall_r_valid", 32'(r_valid), 32'd0);
    end
    out_ready = 1'b1;
    repeat (6) tick();

    // Random stream of 200 words across pointer wrap.
    pushed = 0;
    for (int c = 0; c < 5000 && pushed < 200; c++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if (q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
        push($urandom);
        pushed++;
      end
    end
    check_eq("stream_pushed", 32'(pushed), 32'd200);
    out_ready = 1'b1;
    for (int c = 0; c < 200 && q.size() != 0; c++) tick();
    check_eq("stream_drained", 32'(q.size()), 32'd0);
    repeat (3) tick();
    check_eq("stream_empty", 32'(r_empty), 32'd1);

    // Reset while a word is held on the output.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(32'h3000 + 32'(i));
    repeat (5) tick();
    check_eq("pre_rst_out_valid", 32'(out_valid), 32'd1);
    r_rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_r_gptr", 32'(r_gptr), 32'd0);
    check_eq("midrst_r_valid", 32'(r_valid), 32'd0);
    wcnt   = 0;
    w_gptr = '0;
    q.delete();
    repeat (2) tick();
    r_rst_n = 1'b1;
    repeat (3) tick();

    // Almost-empty threshold: one word on the output plus 4, then plus 5.
    for (int i = 0; i < 5; i++) push(32'h4000 + 32'(i));
    repeat (6) tick();
`ifdef FIFO_RD_LEVEL_EN
    check_eq("lvl4_r_level", 32'(r_level), 32'd4);
    check_eq("lvl4_r_aempty", 32'(r_aempty), 32'd1);
`endif
    push(32'h4005);
    repeat (3) tick();
`ifdef FIFO_RD_LEVEL_EN
    check_eq("lvl5_r_level", 32'(r_level), 32'd5);
    check_eq("lvl5_r_aempty", 32'(r_aempty), 32'd0);
`else
    check_eq("lvl5_r_aempty", 32'(r_aempty), 32'd0);
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 50 && q.size() != 0; c++) tick();
    check_eq("final_drained", 32'(q.size()), 32'd0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter DEPTH, default 64, FIFO word count (power of two).
REQ-002 Parameter ADDR_W, default 6, log2(DEPTH).
REQ-003 Parameter WIDTH, default 32, data word width.
REQ-004 Parameter AE_THRESH, default 4, almost-empty threshold in words.
REQ-005 r_clk  input  1  read-domain clock; the block's only clock.
REQ-006 r_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 w_gptr  input  ADDR_W+1  write pointer, Gray coded, from write domain (asynchronous to r_clk).
REQ-008 r_gptr  output  ADDR_W+1  registered read pointer, Gray coded, to write domain.
REQ-009 r_addr  output  ADDR_W  memory read address (low ADDR_W bits of binary read pointer).
REQ-010 r_valid  output  1  memory read enable; memory returns r_data one r_clk edge later.
REQ-011 r_data  input  WIDTH  memory read data; memory holds it while r_valid is low.
REQ-012 out_data  output  WIDTH  head-of-FIFO word (first-word-fall-through); equals r_data.
REQ-013 out_valid  output  1  out_data holds a valid word.
REQ-014 out_ready  input  1  consumer accepts out_data this cycle.
REQ-015 r_empty  output  1  no unread word in memory (excluding word on out_data).
REQ-016 r_aempty  output  1  r_level <= AE_THRESH.

Function
REQ-017 w_gptr shall pass a two-flop synchronizer (wq1, wq2) in r_clk before any use.
REQ-018 r_empty = (r_gptr == wq2); combinational from registered values.
REQ-019 Two-state FSM: IDLE (out_valid=0), VALID (out_valid=1).
REQ-020 r_valid = !r_empty && (state==IDLE || out_ready); no other read is ever issued.
REQ-021 On r_valid: binary read pointer +1 (wraps mod 2*DEPTH), r_gptr = bin^(bin>>1) registered same edge.
REQ-022 IDLE->VALID on r_valid; VALID->IDLE when out_ready && r_empty; otherwise hold.
REQ-023 Handshake in VALID with !r_empty: new word on out_data next cycle, out_valid stays 1 (one word per cycle).
REQ-024 out_data/out_valid shall not change while out_valid && !out_ready.
REQ-025 out_ready in IDLE ignored; r_valid never asserted while r_empty (no underflow).
REQ-026 r_level = gray2bin(wq2) - rbin, ADDR_W+1 bits, mod 2^(ADDR_W+1); range 0..DEPTH.
REQ-027 Pointer wrap at 2*DEPTH shall leave r_empty and r_level correct.
REQ-028 Write-side change shall reach r_empty deassert in exactly 2 r_clk edges.

Reset
REQ-029 r_rst_n low: rbin=0, r_gptr=0, wq1=wq2=0, state IDLE; outputs out_valid=0, r_valid=0, r_empty=1, r_aempty=1, r_addr=0.
REQ-030 Reset mid-transfer takes effect immediately, drops out_valid, discards in-flight word.

Configuration
REQ-031 Macro FIFO_RD_LEVEL_EN defined: r_level output port (ADDR_W+1 bits) present and r_aempty per REQ-016.
REQ-032 Without FIFO_RD_LEVEL_EN: no r_level port, no level subtractor; r_aempty tied to r_empty.

Structure
REQ-033 Shared package fifo_pkg holds DEPTH/ADDR_W defaults and bin2gray/gray2bin functions, reused by write controller.
REQ-034 One sub-module ptr_sync (parameterized-width two-flop synchronizer, async active-low reset) instantiated for w_gptr.

Verification
REQ-035 Reset, w_gptr=0 -> r_empty=1, out_valid=0, r_valid never 1 over 20 cycles.
REQ-036 w_gptr 0->1 (one word 0xA5A5A5A5) -> r_valid 1 on cycle 2 after change, out_valid=1 cycle 3, out_data=0xA5A5A5A5, r_gptr=1.
REQ-037 8 words preloaded, out_ready=1 constant -> 8 consecutive out_valid cycles, data in order, then IDLE, r_empty=1.
REQ-038 out_valid=1, out_ready=0 for 10 cycles -> out_data stable, r_valid=0, r_gptr unchanged.
REQ-039 Stream 200 words through DEPTH=64 (pointer wraps at 128) -> no loss/duplication, r_empty only when caught up.
REQ-040 r_rst_n low mid-stream (out_valid=1) -> same cycle out_valid=0, r_gptr=0; with FIFO_RD_LEVEL_EN, r_level=4 at 4 words queued gives r_aempty=1, 5 gives 0.
